// File: rtl/cycle_sequencer_pkg.sv
// Shared constants for the cycle sequencer: control-decoder micro-states,
// sequencer FSM encodings visible to debug logic, and small helpers.
package cycle_sequencer_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] STATE_NEXT       = 4'h0;
    localparam logic [STATE_W-1:0] STATE_FETCH_PC   = 4'h1;
    localparam logic [STATE_W-1:0] STATE_FETCH_INST = 4'h2;
    localparam logic [STATE_W-1:0] STATE_HALT       = 4'h3;
    localparam logic [STATE_W-1:0] STATE_JUMP       = 4'h4;
    localparam logic [STATE_W-1:0] STATE_OUT        = 4'h5;
    localparam logic [STATE_W-1:0] STATE_ALU        = 4'h6;
    localparam logic [STATE_W-1:0] STATE_MEM_ADDR   = 4'h7;
    localparam logic [STATE_W-1:0] STATE_MEM_READ   = 4'h8;
    localparam logic [STATE_W-1:0] STATE_REG_WRITE  = 4'h9;

    localparam logic [1:0] SEQ_PAUSE = 2'd0;
    localparam logic [1:0] SEQ_RUN   = 2'd1;
    localparam logic [1:0] SEQ_HALT  = 2'd2;
    localparam logic [1:0] SEQ_FAULT = 2'd3;

    typedef enum logic [1:0] {
        S_PAUSE = SEQ_PAUSE,
        S_RUN   = SEQ_RUN,
        S_HALT  = SEQ_HALT,
        S_FAULT = SEQ_FAULT
    } seq_state_e;

    // Absorbing states: only reset leaves them.
    function automatic logic seq_is_stopped(input seq_state_e s);
        return (s == S_HALT) || (s == S_FAULT);
    endfunction

endpackage

// File: rtl/cycle_sequencer.sv
// Micro-cycle sequencer closing the fetch/execute loop with the control
// decoder: free-run, single-step and sticky halt/fault handling.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int CYCLE_W   = 4,
    parameter int MAX_CYCLE = 7,
    parameter int ICOUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STATE_W-1:0]  state,
    input  logic                run,
    input  logic                step_mode,
    input  logic                step,
    output logic [CYCLE_W-1:0]  cycle,
    output logic                active,
    output logic                instr_done,
    output logic [ICOUNT_W-1:0] instr_count,
    output logic                halted,
    output logic                fault
);

    localparam logic [CYCLE_W-1:0] CYC_LAST = CYCLE_W'(MAX_CYCLE);

    seq_state_e          fsm_q, fsm_d;
    logic [CYCLE_W-1:0]  cycle_q, cycle_d;
    logic [ICOUNT_W-1:0] count_q, count_d;
    logic                done_q, done_d;
    logic                halted_q, halted_d;
    logic                fault_q, fault_d;
    logic                step_q;
    logic                step_rise;

    assign step_rise = step & ~step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= S_PAUSE;
            cycle_q  <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cycle_q  <= cycle_d;
            count_q  <= count_d;
            done_q   <= done_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            step_q   <= step;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        cycle_d  = cycle_q;
        count_d  = count_q;
        done_d   = 1'b0;
        halted_d = halted_q;
        fault_d  = fault_q;

        unique case (fsm_q)
            S_PAUSE: begin
                if (run && (!step_mode || step_rise)) begin
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
                if (state == STATE_HALT) begin
                    fsm_d    = S_HALT;
                    halted_d = 1'b1;
                end else if (state == STATE_NEXT) begin
                    cycle_d = '0;
                    done_d  = 1'b1;
                    count_d = count_q + ICOUNT_W'(1);
                    // Mode inputs only matter at the retire boundary.
                    if (!run || step_mode) begin
                        fsm_d = S_PAUSE;
                    end
                end else if (cycle_q == CYC_LAST) begin
                    fsm_d   = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    cycle_d = cycle_q + CYCLE_W'(1);
                end
            end
            S_HALT: begin
                fsm_d = S_HALT;
            end
            S_FAULT: begin
                fsm_d = S_FAULT;
            end
            default: begin
                fsm_d = S_PAUSE;
            end
        endcase
    end

    assign cycle       = cycle_q;
    assign active      = (fsm_q == S_RUN);
    assign instr_done  = done_q;
    assign instr_count = count_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Randomized scoreboard bench for cycle_sequencer with an instruction-level
// reference model acting as the control decoder.
module tb_cycle_sequencer;
    import cycle_sequencer_pkg::*;

    localparam int CW   = 4;
    localparam int MAXC = 7;
    localparam int IW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    state;
    logic          run;
    logic          step_mode;
    logic          step;
    logic [CW-1:0] cycle;
    logic          active;
    logic          instr_done;
    logic [IW-1:0] instr_count;
    logic          halted;
    logic          fault;

    cycle_sequencer #(
        .CYCLE_W  (CW),
        .MAX_CYCLE(MAXC),
        .ICOUNT_W (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .run        (run),
        .step_mode  (step_mode),
        .step       (step),
        .cycle      (cycle),
        .active     (active),
        .instr_done (instr_done),
        .instr_count(instr_count),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit act;
        bit done;
        int cnt;
        bit hlt;
        bit flt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    bit m_run, m_hlt, m_flt, m_done, m_prev_step;
    int m_cyc, m_cnt;
    int ins_next;
    bit ins_halt;
    int stuck;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        compared++;
        if (act !== 32'(exp)) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".cycle"}, 32'(cycle), e.cyc);
        chk({tag, ".active"}, 32'(active), int'(e.act));
        chk({tag, ".instr_done"}, 32'(instr_done), int'(e.done));
        chk({tag, ".instr_count"}, 32'(instr_count), e.cnt);
        chk({tag, ".halted"}, 32'(halted), int'(e.hlt));
        chk({tag, ".fault"}, 32'(fault), int'(e.flt));
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.cyc  = m_cyc;
        e.act  = m_run;
        e.done = m_done;
        e.cnt  = m_cnt;
        e.hlt  = m_hlt;
        e.flt  = m_flt;
        return e;
    endfunction

    task automatic model_reset();
        m_run = 0; m_hlt = 0; m_flt = 0; m_done = 0; m_prev_step = 0;
        m_cyc = 0; m_cnt = 0;
    endtask

    // Program generator: mostly ordinary instructions retiring at cycle 2..7,
    // occasionally HLT (halt decoded at cycle 2) or a runaway with no NEXT.
    task automatic pick_instr();
        int r;
        r = $urandom_range(0, 63);
        ins_halt = (r == 0);
        if (r <= 1) ins_next = 99;
        else        ins_next = $urandom_range(2, MAXC);
    endtask

    task automatic model_edge(input bit r, input bit sm, input bit st,
                              input logic [3:0] s);
        bit rise;
        rise = st && !m_prev_step;
        m_prev_step = st;
        m_done = 0;
        if (m_run) begin
            if (s == STATE_HALT) begin
                m_hlt = 1; m_run = 0;
            end else if (s == STATE_NEXT) begin
                m_cyc = 0; m_done = 1;
                m_cnt = (m_cnt + 1) % (1 << IW);
                if (!r || sm) m_run = 0;
            end else if (m_cyc == MAXC) begin
                m_flt = 1; m_run = 0;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end else if (!m_hlt && !m_flt && r && (!sm || rise)) begin
            m_run = 1;
        end
    endtask

    function automatic logic [3:0] filler();
        logic [3:0] s;
        s = 4'($urandom_range(1, 15));
        if (s == STATE_HALT) s = STATE_ALU;
        return s;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk_all("mon", mon_e);
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
        state = STATE_ALU;
        model_reset();
        pick_instr();
        stuck = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", model_snapshot());
        rst = 1'b0;

        for (int n = 0; n < 4000; n++) begin
            if (stuck >= 4 || $urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
                pick_instr();
                stuck = 0;
                #1;
                chk_all("async_rst", model_snapshot());
                #1;
                rst = 1'b0;
            end

            if (run) run = ($urandom_range(0, 29) != 0);
            else     run = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
            step = ($urandom_range(0, 3) == 0);

            if (!m_run)                                state = 4'($urandom);
            else if (ins_halt && m_cyc == 2)           state = STATE_HALT;
            else if (m_cyc == ins_next)                state = STATE_NEXT;
            else                                       state = filler();

            model_edge(run, step_mode, step, state);
            e = model_snapshot();
            q.push_back(e);
            if (m_hlt || m_flt) stuck++;
            if (!m_run || m_done) pick_instr();

            @(negedge clk);
            #1;
        end

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
